// File: rtl/counters_pkg.sv
// Shared encodings for the counter/timer blocks.
// No logic; types and constants only.
// No flow control.
package counters_pkg;

  // Counting behaviour at the range bounds; the spare code behaves as wrap.
  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: one-cycle step strobe every PRESCALE enabled clk cycles.
// step is combinational from the registered phase counter (same-cycle).
// en=0 freezes the phase; clr restarts the phase at 0 and wins over en.
module tick_prescaler #(
  parameter int PRESCALE = 100000000,
  parameter int PS_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

  logic [PS_WIDTH-1:0] ps_cnt;

  // Phase counter: runs 0..PRESCALE-1 while enabled, restarts on clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_cnt <= '0;
    end else if (clr) begin
      ps_cnt <= '0;
    end else if (en) begin
      if (ps_cnt == PS_LAST) begin
        ps_cnt <= '0;
      end else begin
        ps_cnt <= ps_cnt + PS_WIDTH'(1);
      end
    end
  end

  // With PRESCALE=1 the phase stays at 0 == PS_LAST, so every enabled cycle steps.
  assign step = en & (ps_cnt == PS_LAST);

endmodule

// File: rtl/prescaled_updown_counter.sv
// Bounded up/down counter stepping once per PRESCALE clk cycles (wrap/saturate/bounce).
// cnt, tick and tc update on the edge a step is taken: 1 clk after the step cycle.
// No backpressure; cnt_en=0 freezes the prescaler and the count, load acts regardless.
module prescaled_updown_counter
  import counters_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int PRESCALE  = 100000000,
  parameter int PS_WIDTH  = 32,
  parameter int RESET_VAL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             tc,
  output logic             dir
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_e            mode_q;
  logic             step;
  logic             dir_r;
  logic             is_bounce;
  logic             go_up;
  logic             at_upper;
  logic             at_lower;
  logic             at_bound;
  logic             range_bad;
  logic             range_single;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic [WIDTH-1:0] cnt_nxt;
  logic             dir_nxt;
  logic             tick_nxt;
  logic             tc_nxt;

  // A load restarts the prescaler phase so the next step is a full period away.
  tick_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_WIDTH (PS_WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (load),
    .step  (step)
  );

  assign mode_q    = mode_e'(mode);
  assign is_bounce = (mode_q == MODE_BOUNCE);

  // In bounce mode the stored direction drives; otherwise the up_dn pin does.
  assign go_up = is_bounce ? dir_r : up_dn;
  assign dir   = go_up;

  // Inclusive comparisons also catch a count left outside a freshly narrowed range.
  assign at_upper = (cnt >= max_val);
  assign at_lower = (cnt <= min_val);
  assign at_bound = go_up ? at_upper : at_lower;

  assign range_bad    = (min_val > max_val);
  assign range_single = (min_val == max_val);

  // +-1 is only selected when the bound test failed, so neither can overflow.
  assign cnt_inc = cnt + ONE;
  assign cnt_dec = cnt - ONE;

  // Next-state mux: load beats step beats hold; tick/tc are single-cycle pulses.
  always_comb begin
    cnt_nxt  = cnt;
    dir_nxt  = dir_r;
    tick_nxt = 1'b0;
    tc_nxt   = 1'b0;
    if (load) begin
      cnt_nxt = load_val;
    end else if (step) begin
      tick_nxt = 1'b1;
      if (range_bad) begin
        // Inverted bounds: count freezes but the step is still reported.
        cnt_nxt = cnt;
      end else begin
        unique case (mode_q)
          MODE_BOUNCE: begin
            if (range_single) begin
              cnt_nxt = min_val;
              dir_nxt = ~dir_r;
              tc_nxt  = 1'b1;
            end else if (dir_r) begin
              if (at_upper) begin
                cnt_nxt = max_val - ONE;
                dir_nxt = 1'b0;
                tc_nxt  = 1'b1;
              end else begin
                cnt_nxt = cnt_inc;
              end
            end else begin
              if (at_lower) begin
                cnt_nxt = min_val + ONE;
                dir_nxt = 1'b1;
                tc_nxt  = 1'b1;
              end else begin
                cnt_nxt = cnt_dec;
              end
            end
          end
          MODE_SAT: begin
            if (at_bound) begin
              cnt_nxt = go_up ? max_val : min_val;
              tc_nxt  = 1'b1;
            end else begin
              cnt_nxt = go_up ? cnt_inc : cnt_dec;
            end
          end
          MODE_WRAP, MODE_RSVD: begin
            if (at_bound) begin
              cnt_nxt = go_up ? min_val : max_val;
              tc_nxt  = 1'b1;
            end else begin
              cnt_nxt = go_up ? cnt_inc : cnt_dec;
            end
          end
          default: begin
            cnt_nxt = cnt;
          end
        endcase
      end
    end
  end

  // Counter, bounce direction and strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= WIDTH'(RESET_VAL);
      dir_r <= 1'b1;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      dir_r <= dir_nxt;
      tick  <= tick_nxt;
      tc    <= tc_nxt;
    end
  end

endmodule
